// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART frame constants and receiver/transmitter state codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // Mid-bit sample index within a bit period of the given length.
    function automatic logic [15:0] sample_point(input int clks);
        return 16'((clks - 1) / 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit flop-chain synchronizer with selectable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff
    import uart_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_recv.sv
// ============================================================================
// Module      : uart_recv
// Description : 8N1 UART receiver, LSB first, mid-bit sampling, one-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_recv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] c_last_cnt  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_sample_pt = sample_point(CLKS_PER_BIT);

    logic                 w_s2;
    logic [15:0]          w_cnt_inc;
    logic                 w_sample;

    logic [1:0]           r_state;
    logic [15:0]          r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_wait_high;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (din),
        .o_q (w_s2)
    );

    // The counter free-runs modulo CLKS_PER_BIT across bit boundaries, so the
    // state transitions never need to realign it.
    assign w_cnt_inc = (r_cnt == c_last_cnt) ? 16'd0 : r_cnt + 16'd1;
    assign w_sample  = (r_cnt == c_sample_pt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= '0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_wait_high <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (w_s2) begin
                r_wait_high <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    r_cnt     <= 16'd0;
                    r_bit_idx <= 3'd0;
                    if (!w_s2 && !r_wait_high) begin
                        r_cnt   <= w_cnt_inc;
                        r_state <= (c_sample_pt == 16'd0) ? c_DATA : c_START;
                    end
                end

                c_START: begin
                    r_cnt <= w_cnt_inc;
                    if (w_sample) begin
                        if (w_s2) begin
                            r_state <= c_IDLE;
                            r_cnt   <= 16'd0;
                        end else begin
                            r_state <= c_DATA;
                        end
                    end
                end

                c_DATA: begin
                    r_cnt <= w_cnt_inc;
                    if (w_sample) begin
                        r_shift   <= {w_s2, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_state <= c_STOP;
                        end
                    end
                end

                c_STOP: begin
                    r_cnt <= w_cnt_inc;
                    if (w_sample) begin
                        // Leave immediately so a start bit right after the stop bit is caught.
                        r_state <= c_IDLE;
                        r_cnt   <= 16'd0;
                        if (w_s2) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr      <= 1'b1;
                            r_wait_high <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 1, meaning clock cycles per serial bit (legal range 1..65535).
REQ-002 The module SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 The module SHALL have port rst  input  1  synchronous, active-low reset (low at a rising clk edge resets the block).
REQ-004 The module SHALL have port din  input  1  serial line; idle high, 8N1 frame, LSB first.
REQ-005 The module SHALL have port data  output  8  last correctly received byte.
REQ-006 The module SHALL have port valid  output  1  one-cycle pulse; data holds a new good byte.
REQ-007 The module SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 The module SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-009 din SHALL pass through a 2-flop synchronizer (s1, s2), both reset to 1; all decisions use s2 only.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-011 Sample point H SHALL be (CLKS_PER_BIT-1)/2 (integer division); a bit counter counts 0..CLKS_PER_BIT-1 within each bit and the bit is sampled when the counter equals H.
REQ-012 IDLE: s2==0 SHALL start a frame; if H==0 the start bit is confirmed immediately and the FSM goes to DATA, otherwise it goes to START with the counter at 1.
REQ-013 START: at the sample point, s2==1 SHALL be treated as a glitch (return to IDLE, no pulse); s2==0 SHALL continue to DATA aligned to the next bit boundary.
REQ-014 DATA: 8 bits SHALL be sampled in order into a shift register, LSB first; a 3-bit index wraps from 7 to STOP after bit 7.
REQ-015 STOP: at the sample point, s2==1 SHALL load data from the shift register and pulse valid for exactly one cycle; s2==0 SHALL pulse frame_err for exactly one cycle and leave data unchanged.
REQ-016 After the stop sample the FSM SHALL enter IDLE immediately, without waiting for the remainder of the stop bit, so that a start bit directly following the stop bit is accepted.
REQ-017 valid and frame_err SHALL never be high in the same cycle; data SHALL change only in the cycle valid rises.
REQ-018 With CLKS_PER_BIT=1, a start bit present on din in cycle t SHALL produce valid (or frame_err) high in cycle t+12; back-to-back frames (period 10 cycles) SHALL each produce a pulse, 10 cycles apart.
REQ-019 A line held low while the block is in IDLE and not following a completed frame SHALL be received as a 0x00 byte followed by frame_err, and no further frame SHALL start until s2 returns high.

Reset
REQ-020 On reset: state=IDLE, all counters=0, shift register=0, data=8'h00, valid=0, frame_err=0, busy=0, s1=s2=1.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; reception resumes on the first falling s2 after release.

Structure
REQ-022 The state encodings (2-bit) and the frame constants DATA_BITS=8 and SYNC_STAGES=2 SHALL reside in a shared uart_pkg package also used by the transmitter.
REQ-023 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, reset value parameterized); everything else stays in uart_recv.

Verification
REQ-024 With N=1, the transmitter sends 0xA5 to din -> exactly one valid pulse, data=0xA5, frame_err never high.
REQ-025 With N=1, stop bit forced low on 0x3C -> frame_err pulses once in cycle t+12, valid stays 0, data keeps its previous value.
REQ-026 With N=16, a 3-cycle low glitch on an idle line -> no pulse, busy returns low within 8 cycles of the glitch ending.
REQ-027 With N=1, back-to-back 0x00, 0xFF, 0x81 -> three valid pulses 10 cycles apart with data matching in order.
REQ-028 With N=4, rst driven low during bit 4 of 0x55 -> no pulse, data=0x00; the next frame 0x12 is received correctly.
REQ-029 With N=1, loopback of the transmitter over 256 random bytes -> all bytes received in order, zero frame_err.
